// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: filtered serial front end, RX FIFO and CPU registers.
// Define PS2_KEYBOARD_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 8191
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] data_bus,
    input  logic [1:0] address,
    input  logic       cs,
    input  logic       write,
    input  logic       read,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    byte_q, byte_d;
    logic          set_frm, set_par;
    logic          par_bad;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic          rd_q;
    logic          ready_q;
    logic          ovf_q, ovf_d;
    logic          frm_q, frm_d;
    logic          perr_q, perr_d;

    logic          strobe, ctl_we, flush, clr;
    logic          empty, full, pop, wr_en;
    logic [7:0]    status, rd_data;
    logic          unused_ok;

`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
    logic par_q, par_d;
    assign par_bad = ~^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    // Level must persist FILTER_LEN samples before the filtered clock follows.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = '0;
        push_d   = 1'b0;
        byte_d   = byte_q;
        set_frm  = 1'b0;
        set_par  = 1'b0;
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
        par_d    = par_q;
`endif
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
                    par_d   = dat_s2_q;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s2_q) begin
                        set_frm = 1'b1;
                    end else if (par_bad) begin
                        set_par = 1'b1;
                    end else begin
                        push_d = 1'b1;
                        byte_d = shift_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d  = IDLE;
                shift_d  = '0;
                bitcnt_d = '0;
                set_frm  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign strobe = cs & read & (address == 2'd0);
    assign ctl_we = cs & write & (address == 2'd2);
    assign flush  = ctl_we & data_bus[0];
    assign clr    = ctl_we & data_bus[1];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign pop    = strobe & ~rd_q & ~empty;
    assign wr_en  = push_q & (~full | pop);

    assign unused_ok = &{1'b0, data_bus[7:2]};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = byte_q;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(pop);
        end
    end

    // New error events take priority over a clear in the same cycle.
    always_comb begin
        ovf_d  = clr ? 1'b0 : ovf_q;
        frm_d  = clr ? 1'b0 : frm_q;
        perr_d = clr ? 1'b0 : perr_q;
        if (push_q && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (set_frm) begin
            frm_d = 1'b1;
        end
        if (set_par) begin
            perr_d = 1'b1;
        end
    end

    assign status = {3'b000, frm_q, perr_q, ovf_q, full, ~empty};

    always_comb begin
        rd_data = 8'h00;
        case (address)
            2'd0: rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
            2'd1: rd_data = status;
            2'd3: rd_data = 8'(count_q);
            default: rd_data = 8'h00;
        endcase
    end

    assign data_bus = (cs & read) ? rd_data : 8'hzz;
    assign ready    = ready_q;

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            byte_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_q        <= 1'b0;
            ready_q     <= 1'b0;
            ovf_q       <= 1'b0;
            frm_q       <= 1'b0;
            perr_q      <= 1'b0;
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            byte_q      <= byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_q        <= strobe;
            ready_q     <= (count_d != '0);
            ovf_q       <= ovf_d;
            frm_q       <= frm_d;
            perr_q      <= perr_d;
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
            par_q       <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed and randomized bench for ps2_keyboard against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_keyboard;
    localparam int DEPTH = 8;
    localparam int TMO   = 8191;
    localparam int HALF  = 12;
`ifdef PS2_KEYBOARD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = 2'd0;
    logic       cs = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready;
    wire  [7:0] data_bus;
    logic       drv = 1'b0;
    logic [7:0] wdata = 8'h00;

    assign data_bus = drv ? wdata : 8'hzz;

    always #5 clk = ~clk;

    ps2_keyboard #(
        .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(4),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_bus(data_bus),
        .address(address),
        .cs(cs),
        .write(write),
        .read(read),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ready(ready)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    bit m_ovf, m_par, m_frm;

    function automatic logic [7:0] m_status();
        return {3'b000, m_frm, m_par, m_ovf,
                mq.size() == DEPTH, mq.size() != 0};
    endfunction

    function automatic void m_frame(logic [7:0] d, bit par_ok, bit stop);
        if (!stop) m_frm = 1'b1;
        else if (!par_ok && PAR_EN) m_par = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(bit b, bit glitch);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        if (glitch) begin
            tick(7);
            ps2_clk = 1'b0;
            tick(1);
            ps2_clk = 1'b1;
            tick(HALF - 8);
        end else begin
            tick(HALF);
        end
    endtask

    task automatic send_frame(logic [7:0] d, bit par_flip, bit stop, int gbit);
        logic p;
        p = (~^d) ^ par_flip;
        send_bit(1'b0, gbit == 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gbit == i + 1);
        send_bit(p, gbit == 9);
        send_bit(stop, gbit == 10);
        ps2_data = 1'b1;
        tick(6);
        m_frame(d, !par_flip, stop);
    endtask

    task automatic cpu_read(logic [1:0] a, output logic [7:0] v);
        @(negedge clk);
        address = a;
        cs = 1'b1;
        read = 1'b1;
        #1 v = data_bus;
        @(negedge clk);
        cs = 1'b0;
        read = 1'b0;
    endtask

    task automatic rd_check(logic [1:0] a, string tag);
        logic [7:0] exp, v;
        unique case (a)
            2'd0: exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
            2'd1: exp = m_status();
            2'd3: exp = 8'(mq.size());
            default: exp = 8'h00;
        endcase
        cpu_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic cpu_write(logic [1:0] a, logic [7:0] v);
        @(negedge clk);
        address = a;
        cs = 1'b1;
        write = 1'b1;
        drv = 1'b1;
        wdata = v;
        @(negedge clk);
        cs = 1'b0;
        write = 1'b0;
        drv = 1'b0;
        if (a == 2'd2) begin
            if (v[0]) mq.delete();
            if (v[1]) begin
                m_ovf = 1'b0;
                m_par = 1'b0;
                m_frm = 1'b0;
            end
        end
    endtask

    task automatic chk_ready(string tag);
        check(tag, {7'b0, ready}, {7'b0, mq.size() != 0});
    endtask

    initial begin
        logic [7:0] d;
        int kind;
        m_reset();
        tick(5);
        reset = 1'b0;
        tick(2);

        chk_ready("rst_ready");
        rd_check(2'd1, "rst_status");
        rd_check(2'd3, "rst_count");
        rd_check(2'd0, "rst_data_empty");
        rd_check(2'd2, "ctrl_reads_zero");

        send_frame(8'h1C, 1'b0, 1'b1, -1);
        chk_ready("f1c_ready");
        rd_check(2'd3, "f1c_count");
        rd_check(2'd0, "f1c_data");
        tick(2);
        chk_ready("f1c_ready_after");
        rd_check(2'd3, "f1c_count_after");

        send_frame(8'h1C, 1'b1, 1'b1, -1);
        rd_check(2'd1, "badpar_status");
        rd_check(2'd3, "badpar_count");
        rd_check(2'd0, "badpar_data");
        cpu_write(2'd2, 8'h03);
        rd_check(2'd1, "clear_status");

        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 1'b1, -1);
        rd_check(2'd1, "ovf_status");
        rd_check(2'd3, "ovf_count");
        for (int i = 0; i < DEPTH; i++) rd_check(2'd0, "ovf_order");
        cpu_write(2'd2, 8'h02);
        rd_check(2'd1, "ovf_cleared");

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        tick(TMO + 20);
        m_frm = 1'b1;
        rd_check(2'd1, "timeout_status");
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        rd_check(2'd0, "after_timeout_data");
        cpu_write(2'd2, 8'h02);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        send_frame(8'h3C, 1'b0, 1'b1, 4);
        rd_check(2'd3, "hold_count_before");
        @(negedge clk);
        address = 2'd0;
        cs = 1'b1;
        read = 1'b1;
        tick(5);
        cs = 1'b0;
        read = 1'b0;
        void'(mq.pop_front());
        rd_check(2'd3, "hold_count_after");
        rd_check(2'd0, "glitch_data");

        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_reset();
        tick(2);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        rd_check(2'd1, "midrst_status");
        rd_check(2'd0, "midrst_data");

        cpu_write(2'd2, 8'h03);
        for (int it = 0; it < 30; it++) begin
            d = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            send_frame(d, kind == 0, kind != 1, -1);
            if ($urandom_range(0, 2) == 0) rd_check(2'd0, "rnd_data");
            rd_check(2'd1, "rnd_status");
            chk_ready("rnd_ready");
            if (it % 10 == 9) begin
                cpu_write(2'd2, 8'h01);
                rd_check(2'd3, "rnd_flush_count");
            end
        end
        while (mq.size() != 0) rd_check(2'd0, "drain_data");
        rd_check(2'd3, "drain_count");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
